// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the Nexys Starship game blocks.
//   hg_state_e : one-hot hazard generator states
//   LFSR_POLY  : Galois toggle mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
//   ST_*       : repair station indices (bit i of station vectors)
//   lfsr_step  : one Galois LFSR advance
package nexys_starship_pkg;

    typedef enum logic [2:0] {
        HG_IDLE = 3'b001,
        HG_ARM  = 3'b010,
        HG_FIRE = 3'b100
    } hg_state_e;

    localparam logic [15:0] LFSR_POLY = 16'hB400;

    localparam int unsigned ST_BTM   = 0;
    localparam int unsigned ST_TOP   = 1;
    localparam int unsigned ST_LEFT  = 2;
    localparam int unsigned ST_RIGHT = 3;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/nexys_starship_hazard_gen_if.sv
// Break/repair handshake between the hazard generator and the repair stations.
//   br_random  : one-hot break strobe (generator -> stations)
//   random_hex : repair combo for the current hazard (generator -> stations)
//   st_broken  : per-station broken flags, acknowledge the strobe (stations -> generator)
interface nexys_starship_hazard_gen_if #(
    parameter int unsigned NUM_ST = 4
);
    logic [NUM_ST-1:0] br_random;
    logic [3:0]        random_hex;
    logic [NUM_ST-1:0] st_broken;

    modport master (
        output br_random,
        output random_hex,
        input  st_broken
    );

    modport slave (
        input  br_random,
        input  random_hex,
        output st_broken
    );
endinterface

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit Galois LFSR, advances every Clk while out of reset.
//   Clk   : clock
//   Reset : asynchronous active-low reset, loads seed
//   seed  : reset value, must be nonzero (all-zero state is a lock-up)
//   out   : current LFSR state
module nexys_starship_lfsr16
    import nexys_starship_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    logic [15:0] state_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= seed;
        end else begin
            state_q <= lfsr_step(state_q);
        end
    end

    assign out = state_q;

endmodule

// File: rtl/nexys_starship_hazard_gen.sv
// Hazard generator: decides when and which repair station breaks, and with which combo.
//   Clk, Reset    : clock, asynchronous active-low reset
//   timer_tick    : slow game tick (one-cycle enable)
//   play_flag     : game start request (sampled in IDLE only)
//   gameover_ctrl : forces return to IDLE
//   hz            : break strobe / combo out, station broken flags in
//   hazard_count  : acknowledged hazards since game start, saturating
//   q_HG_*        : one-hot state flags
module nexys_starship_hazard_gen
    import nexys_starship_pkg::*;
#(
    parameter int unsigned NUM_ST   = 4,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter logic [7:0]  MIN_GAP  = 8'd4,
    parameter logic [7:0]  GAP_MASK = 8'h0F,
    parameter logic [3:0]  FIRE_TO  = 4'd8
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         timer_tick,
    input  logic                         play_flag,
    input  logic                         gameover_ctrl,
    nexys_starship_hazard_gen_if.master  hz,
    output logic [7:0]                   hazard_count,
    output logic                         q_HG_Idle,
    output logic                         q_HG_Arm,
    output logic                         q_HG_Fire
);

    localparam int unsigned IdxW = (NUM_ST > 1) ? $clog2(NUM_ST) : 1;

    hg_state_e         state_q, state_d;
    logic [7:0]        gap_q, gap_d;
    logic [3:0]        to_q, to_d;
    logic [NUM_ST-1:0] br_q, br_d;
    logic [3:0]        hex_q, hex_d;
    logic [7:0]        count_q, count_d;

    logic [15:0]       lfsr_q;
    logic [7:0]        gap_load;
    logic [3:0]        hex_pick;
    logic [NUM_ST-1:0] cand;
    logic [3:0]        to_inc;
    logic              ack;
    logic              unused_lfsr;

    nexys_starship_lfsr16 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .seed  (SEED),
        .out   (lfsr_q)
    );

    // First non-broken station scanning upward from start, wrapping; all-zero if none.
    function automatic logic [NUM_ST-1:0] scan_target(input logic [1:0]        start,
                                                      input logic [NUM_ST-1:0] broken);
        logic [NUM_ST-1:0] sel;
        int unsigned       idx;
        sel = '0;
        for (int unsigned k = 0; k < NUM_ST; k++) begin
            idx = (32'(start) + k) % NUM_ST;
            if ((sel == '0) && !broken[idx[IdxW-1:0]]) begin
                sel[idx[IdxW-1:0]] = 1'b1;
            end
        end
        return sel;
    endfunction

    assign gap_load    = MIN_GAP + (lfsr_q[7:0] & GAP_MASK);
    // Combo 0 is reserved, so a zero nibble maps to F.
    assign hex_pick    = (lfsr_q[11:8] == 4'h0) ? 4'hF : lfsr_q[11:8];
    assign cand        = scan_target(lfsr_q[1:0], hz.st_broken);
    assign ack         = |(hz.st_broken & br_q);
    assign to_inc      = to_q + 4'd1;
    assign unused_lfsr = ^lfsr_q[15:12];

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        to_d    = to_q;
        br_d    = br_q;
        hex_d   = hex_q;
        count_d = count_q;
        case (state_q)
            HG_IDLE: begin
                br_d  = '0;
                hex_d = 4'h0;
                to_d  = 4'h0;
                if (play_flag) begin
                    state_d = HG_ARM;
                    count_d = 8'h00;
                    gap_d   = gap_load;
                end
            end
            HG_ARM: begin
                br_d = '0;
                if (gameover_ctrl) begin
                    state_d = HG_IDLE;
                    hex_d   = 4'h0;
                end else if (gap_q != 8'h00) begin
                    if (timer_tick) begin
                        gap_d = gap_q - 8'd1;
                    end
                end else if (cand != '0) begin
                    // Gap stays at 0 while every station is broken, so this retries each Clk.
                    state_d = HG_FIRE;
                    br_d    = cand;
                    hex_d   = hex_pick;
                    to_d    = 4'h0;
                end
            end
            HG_FIRE: begin
                if (gameover_ctrl) begin
                    state_d = HG_IDLE;
                    br_d    = '0;
                    hex_d   = 4'h0;
                end else if (ack) begin
                    state_d = HG_ARM;
                    br_d    = '0;
                    gap_d   = gap_load;
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                end else if (timer_tick) begin
                    if (to_inc == FIRE_TO) begin
                        state_d = HG_ARM;
                        br_d    = '0;
                        gap_d   = gap_load;
                    end else begin
                        to_d = to_inc;
                    end
                end
            end
            default: begin
                state_d = HG_IDLE;
                br_d    = '0;
                hex_d   = 4'h0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= HG_IDLE;
            gap_q   <= 8'h00;
            to_q    <= 4'h0;
            br_q    <= '0;
            hex_q   <= 4'h0;
            count_q <= 8'h00;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
            br_q    <= br_d;
            hex_q   <= hex_d;
            count_q <= count_d;
        end
    end

    assign hz.br_random  = br_q;
    assign hz.random_hex = hex_q;
    assign hazard_count  = count_q;
    assign q_HG_Idle     = state_q[0];
    assign q_HG_Arm      = state_q[1];
    assign q_HG_Fire     = state_q[2];

endmodule
